// File: rtl/scatter32_pkg.sv
// Shared sizing constants and FSM state type for the scatter32 storage block.
package scatter32_pkg;

    localparam int unsigned DEPTH  = 32;
    localparam int unsigned ADDR_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/scatter32_decoder_5_to_32.sv
// Converts a 5-bit index plus enable into a one-hot write-enable vector.
module decoder_5_to_32
    import scatter32_pkg::*;
(
    input  logic [ADDR_W-1:0] idx,
    input  logic              ena,
    output logic [DEPTH-1:0]  onehot
);

    always_comb begin
        onehot = '0;
        if (ena) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/scatter32.sv
// 32-entry register file loaded either by direct writes or by a sequential
// stream fill of entries 0..31; direct writes take priority over stream beats.
module scatter32
    import scatter32_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_ena,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [N-1:0]        wr_data,
    input  logic                start,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [N-1:0]        s_data,
    output logic                busy,
    output logic                done,
    output logic [DEPTH-1:0]    written,
    output logic [N-1:0]        out00,
    output logic [N-1:0]        out01,
    output logic [N-1:0]        out02,
    output logic [N-1:0]        out03,
    output logic [N-1:0]        out04,
    output logic [N-1:0]        out05,
    output logic [N-1:0]        out06,
    output logic [N-1:0]        out07,
    output logic [N-1:0]        out08,
    output logic [N-1:0]        out09,
    output logic [N-1:0]        out10,
    output logic [N-1:0]        out11,
    output logic [N-1:0]        out12,
    output logic [N-1:0]        out13,
    output logic [N-1:0]        out14,
    output logic [N-1:0]        out15,
    output logic [N-1:0]        out16,
    output logic [N-1:0]        out17,
    output logic [N-1:0]        out18,
    output logic [N-1:0]        out19,
    output logic [N-1:0]        out20,
    output logic [N-1:0]        out21,
    output logic [N-1:0]        out22,
    output logic [N-1:0]        out23,
    output logic [N-1:0]        out24,
    output logic [N-1:0]        out25,
    output logic [N-1:0]        out26,
    output logic [N-1:0]        out27,
    output logic [N-1:0]        out28,
    output logic [N-1:0]        out29,
    output logic [N-1:0]        out30,
    output logic [N-1:0]        out31
);

    state_t              state;
    logic [ADDR_W-1:0]   fill_idx;
    logic [N-1:0]        mem [DEPTH];

    logic                in_fill;
    logic                beat_acc;
    logic                any_we;
    logic [ADDR_W-1:0]   sel_idx;
    logic [N-1:0]        sel_data;
    logic [DEPTH-1:0]    we_vec;

    assign in_fill  = (state == FILL);
    assign s_ready  = in_fill && !wr_ena;
    assign beat_acc = s_ready && s_valid;
    assign any_we   = wr_ena || beat_acc;

    // One shared decode path: the direct-write port owns the index whenever it fires.
    assign sel_idx  = wr_ena ? wr_addr : fill_idx;
    assign sel_data = wr_ena ? wr_data : s_data;

    decoder_5_to_32 u_dec (
        .idx    (sel_idx),
        .ena    (any_we),
        .onehot (we_vec)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (we_vec[i]) begin
                    mem[i] <= sel_data;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            fill_idx <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            written  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= FILL;
                        fill_idx <= '0;
                        busy     <= 1'b1;
                    end
                end
                FILL: begin
                    if (beat_acc) begin
                        if (fill_idx == ADDR_W'(DEPTH - 1)) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            fill_idx <= fill_idx + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase

            // A fill request clears the bitmap, but a same-cycle direct write still marks its entry.
            if (state == IDLE && start) begin
                written <= we_vec;
            end else begin
                written <= written | we_vec;
            end
        end
    end

    assign out00 = mem[0];
    assign out01 = mem[1];
    assign out02 = mem[2];
    assign out03 = mem[3];
    assign out04 = mem[4];
    assign out05 = mem[5];
    assign out06 = mem[6];
    assign out07 = mem[7];
    assign out08 = mem[8];
    assign out09 = mem[9];
    assign out10 = mem[10];
    assign out11 = mem[11];
    assign out12 = mem[12];
    assign out13 = mem[13];
    assign out14 = mem[14];
    assign out15 = mem[15];
    assign out16 = mem[16];
    assign out17 = mem[17];
    assign out18 = mem[18];
    assign out19 = mem[19];
    assign out20 = mem[20];
    assign out21 = mem[21];
    assign out22 = mem[22];
    assign out23 = mem[23];
    assign out24 = mem[24];
    assign out25 = mem[25];
    assign out26 = mem[26];
    assign out27 = mem[27];
    assign out28 = mem[28];
    assign out29 = mem[29];
    assign out30 = mem[30];
    assign out31 = mem[31];

endmodule

// File: tb/tb_scatter32.sv
// Directed and randomized checks of scatter32 against a behavioural model of
// the register file, bitmap and fill progress.
module tb_scatter32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_ena = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        start = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] s_data = '0;
    logic        busy;
    logic        done;
    logic [31:0] written;
    logic [31:0] obs [32];

    int vectors = 0;
    int miscompares = 0;
    int done_seen = 0;

    logic [31:0] ref_mem [32];
    logic [31:0] ref_written;
    int          fill_pos;     // next entry the stream will write, -1 when no fill is running
    bit          completing;   // fill finished last edge; completion is being signalled

    always #5 clk = ~clk;

    scatter32 #(.N(32)) dut (
        .clk(clk), .rst(rst), .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .busy(busy), .done(done), .written(written),
        .out00(obs[0]),  .out01(obs[1]),  .out02(obs[2]),  .out03(obs[3]),
        .out04(obs[4]),  .out05(obs[5]),  .out06(obs[6]),  .out07(obs[7]),
        .out08(obs[8]),  .out09(obs[9]),  .out10(obs[10]), .out11(obs[11]),
        .out12(obs[12]), .out13(obs[13]), .out14(obs[14]), .out15(obs[15]),
        .out16(obs[16]), .out17(obs[17]), .out18(obs[18]), .out19(obs[19]),
        .out20(obs[20]), .out21(obs[21]), .out22(obs[22]), .out23(obs[23]),
        .out24(obs[24]), .out25(obs[25]), .out26(obs[26]), .out27(obs[27]),
        .out28(obs[28]), .out29(obs[29]), .out30(obs[30]), .out31(obs[31])
    );

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) ref_mem[i] = '0;
        ref_written = '0;
        fill_pos = -1;
        completing = 1'b0;
    endtask

    task automatic check_all();
        check("busy", {31'd0, busy}, {31'd0, (fill_pos >= 0) || completing});
        check("done", {31'd0, done}, {31'd0, completing});
        check("written", written, ref_written);
        for (int i = 0; i < 32; i++) check($sformatf("out%0d", i), obs[i], ref_mem[i]);
        if (done) done_seen++;
    endtask

    task automatic model_edge(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                              input logic st, input logic sv, input logic [31:0] sd);
        if (we) ref_mem[wa] = wd;
        if (completing) begin
            completing = 1'b0;
        end else if (fill_pos >= 0) begin
            if (sv && !we) begin
                ref_mem[fill_pos] = sd;
                ref_written[fill_pos] = 1'b1;
                if (fill_pos == 31) begin
                    fill_pos = -1;
                    completing = 1'b1;
                end else begin
                    fill_pos++;
                end
            end
        end else if (st) begin
            ref_written = '0;
            fill_pos = 0;
        end
        if (we) ref_written[wa] = 1'b1;
    endtask

    // Called just after a falling edge; applies one cycle of stimulus.
    task automatic cycle(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic st, input logic sv, input logic [31:0] sd);
        wr_ena = we; wr_addr = wa; wr_data = wd; start = st; s_valid = sv; s_data = sd;
        #1;
        check("s_ready", {31'd0, s_ready}, {31'd0, (fill_pos >= 0) && !completing && !we});
        @(posedge clk);
        model_edge(we, wa, wd, st, sv, sd);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle_cycle();
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #2;
        model_reset();
        check_all();
        check("s_ready_rst", {31'd0, s_ready}, 32'd0);
        #1 rst = 1'b0;
    endtask

    initial begin
        int d0;
        int k;
        model_reset();
        wr_ena = 1'b0;
        repeat (2) @(negedge clk);
        check_all();
        rst = 1'b0;

        // Single direct write into entry 7
        cycle(1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 1'b0, 32'd0);
        check("out07_direct", obs[7], 32'hDEADBEEF);
        check("written_direct", written, 32'h0000_0080);
        idle_cycle();

        // Back-to-back full fill
        d0 = done_seen;
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 32'd0);
        for (int i = 0; i < 32; i++) cycle(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 32'h100 + i);
        check("done_after_beat31", {31'd0, done}, 32'd1);
        idle_cycle();
        check("busy_low_after_done", {31'd0, busy}, 32'd0);
        check("written_full", written, 32'hFFFF_FFFF);
        check("out31_fill", obs[31], 32'h11F);
        check("done_count_fill", done_seen - d0, 1);

        // Fill with valid toggling every other cycle
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 32'd0);
        k = 0;
        while (!done && k < 100) begin
            k++;
            cycle(1'b0, 5'd0, 32'd0, 1'b0, k[0], 32'h100 + (k - 1) / 2);
        end
        check("toggle_done_latency", k, (k == 64) ? 64 : 63);
        check("out00_toggle", obs[0], 32'h100);
        check("out31_toggle", obs[31], 32'h11F);
        idle_cycle();

        // Direct write collides with a stream beat at fill index 5
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 32'd0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 32'hA00 + i);
        cycle(1'b1, 5'd20, 32'h55, 1'b0, 1'b1, 32'hBAD);
        check("out20_collide", obs[20], 32'h55);
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 32'hA05);
        check("out05_after_collide", obs[5], 32'hA05);
        for (int i = 0; i < 3; i++) idle_cycle();

        // Reset aborts a fill after 10 beats
        d0 = done_seen;
        for (int i = 0; i < 10; i++) cycle(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 32'hC00 + i);
        pulse_reset();
        for (int i = 0; i < 3; i++) idle_cycle();
        check("no_done_after_abort", done_seen - d0, 0);
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 32'd0);
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 32'hE00);
        check("refill_from_0", obs[0], 32'hE00);

        // start held high through FILL and DONE
        d0 = done_seen;
        for (int i = 1; i < 32; i++) cycle(1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 32'hE00 + i);
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 32'd0);
        check("one_done_with_start", done_seen - d0, 1);
        idle_cycle();

        // start together with a direct write in IDLE
        cycle(1'b1, 5'd9, 32'h99, 1'b1, 1'b0, 32'd0);
        check("written_start_we", written, 32'h0000_0200);
        pulse_reset();

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            logic        r_we, r_st, r_sv;
            logic [4:0]  r_wa;
            r_we = ($urandom_range(0, 7) == 0);
            r_st = ($urandom_range(0, 5) == 0);
            r_sv = ($urandom_range(0, 9) < 7);
            r_wa = 5'($urandom_range(0, 31));
            cycle(r_we, r_wa, $urandom, r_st, r_sv, $urandom);
            if (n == 300) pulse_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/scatter32.md
SCATTER32 -- requirements
Module: scatter32

Interface
REQ-001 N, default 32, data width of every data port and storage word.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 wr_ena  input  1  direct-write strobe.
REQ-005 wr_addr  input  5  direct-write target index 0..31.
REQ-006 wr_data  input  N  direct-write data.
REQ-007 start  input  1  request a sequential fill of entries 0..31.
REQ-008 s_valid  input  1  stream beat valid.
REQ-009 s_ready  output  1  stream beat accepted when s_valid and s_ready are both high on a clk edge.
REQ-010 s_data  input  N  stream beat data.
REQ-011 busy  output  1  high while a fill is in progress or completing.
REQ-012 done  output  1  single-cycle pulse on fill completion.
REQ-013 written  output  32  bit i high = out{i} written since last clear.
REQ-014 out00..out31  output  N each  registered storage words, two-digit zero-padded index.

Function
REQ-015 Direct write SHALL load wr_data into out[wr_addr] and set written[wr_addr] on the edge where wr_ena=1, in any FSM state; visible one cycle later.
REQ-016 FSM SHALL have states IDLE, FILL, DONE.
REQ-017 IDLE: s_ready=0, busy=0, done=0; start=1 -> FILL, fill index <= 0, written <= all zeros.
REQ-018 FILL: s_ready SHALL equal ~wr_ena (combinational), busy=1; each accepted beat writes s_data to out[index], sets written[index], index <= index+1.
REQ-019 Accepted beat at index 31 SHALL transition FILL -> DONE; index SHALL NOT wrap to 0 within a fill.
REQ-020 DONE: busy=1, done=1, s_ready=0 for exactly one cycle, then -> IDLE unconditionally.
REQ-021 start SHALL be ignored in FILL and DONE.
REQ-022 s_valid with s_ready=0 SHALL have no effect; stalls (s_valid=0) in FILL SHALL hold index indefinitely.
REQ-023 wr_ena in FILL SHALL win the cycle: direct write performed, no stream beat accepted, index unchanged.
REQ-024 start with wr_ena in IDLE: bitmap cleared except written[wr_addr], which SHALL end 1.
REQ-025 All outputs except s_ready SHALL be driven from flops; no combinational input-to-out path.
REQ-026 Entries not written SHALL hold their previous value.

Reset
REQ-027 rst=1 SHALL asynchronously force out00..out31=0, written=0, index=0, state=IDLE, done=0, busy=0, s_ready=0.
REQ-028 rst asserted mid-fill SHALL abort the fill with no done pulse; first edge after deassertion behaves as IDLE.

Structure
REQ-029 Shared package SHALL hold DEPTH=32, ADDR_W=5, and the FSM state enum.
REQ-030 One sub-module decoder_5_to_32 (5-bit index + enable -> 32-bit one-hot write-enable) SHALL be instantiated for the write-enable decode, muxing index from wr_addr or fill counter.

Verification
REQ-031 Reset then wr_ena, wr_addr=7, wr_data=0xDEADBEEF -> next cycle out07=0xDEADBEEF, written=0x00000080, all other outs 0.
REQ-032 start, then 32 back-to-back beats s_data=i+0x100 -> out{i}=i+0x100 for all i, written=0xFFFFFFFF, done high one cycle after beat 31, busy low next cycle.
REQ-033 Fill with s_valid toggled every other cycle -> same final contents as REQ-032, done 63 or 64 cycles after start per stall pattern.
REQ-034 During FILL at index 5, wr_ena wr_addr=20 data=0x55 with s_valid=1 -> s_ready=0 that cycle, out20=0x55, index stays 5; next beat lands in out05.
REQ-035 rst pulse after 10 beats -> all outs 0, written 0, no done pulse; new start fills from index 0.
REQ-036 start asserted during FILL and in DONE -> ignored; exactly one done pulse per fill.
